legv8_multicycle_ctrl: RTL and testbench
========================================

Name: legv8_multicycle_ctrl

Overview:
Multi-cycle control FSM for the LEGv8 core. It sequences instruction fetch, the ID stage (register file read, sign extension), execute, data memory access and write-back, and produces per-cycle datapath strobes, including RegWrite, Reg2Loc and WRegLoc for the ID block. It handles variable-latency instruction and data memories through ready handshakes, with a watchdog.

Parameters:
INST_SIZE, 32, instruction width
WAIT_MAX, 16, max cycles to wait for a memory ready before bus error (≥1)
WAIT_W, 5, width of the wait counter (≥ clog2(WAIT_MAX+1))

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
inst  in  INST_SIZE  current instruction register contents
zero  in  1  ALU zero flag, valid in EXEC
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
IRWrite  out  1  load instruction register
PCWrite  out  1  update PC
PCSrc  out  1  0 = PC+4, 1 = branch target
RegWrite  out  1  register file write enable
Reg2Loc  out  1  2nd read register = Rt[4:0] (1) / Rm[20:16] (0)
WRegLoc  out  1  write register = X30 (1) / Rd (0)
ALUSrc  out  1  ALU B = ex_data (1) / r_data2 (0)
ALUOp  out  2  00 add, 01 pass B, 10 R-type by opcode
MemRead  out  1  data memory read
MemWrite  out  1  data memory write
MemtoReg  out  1  write-back source = memory
illegal  out  1  1-cycle pulse on undecodable opcode
bus_err  out  1  1-cycle pulse on memory timeout

Behaviour:
- Reset (async, any state): state = FETCH, wait counter = 0, class register = NOP, all outputs 0. An instruction in flight is abandoned with no write, PC update or memory strobe after reset assertion.
- Outputs are Moore, decoded from the state and the instruction class latched in DECODE. inst must be stable from DECODE until the return to FETCH.
- Decode on inst[31:21]:
  - ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550 → RTYPE
  - LDUR 0x7C2 → LOAD
  - STUR 0x7C0 → STORE
  - inst[31:24] 0xB4 → CBZ, 0xB5 → CBNZ
  - inst[31:26] 0x05 → B, 0x25 → BL
  - anything else → ILL
- FETCH:
  - imem_req = 1.
  - On imem_ready: IRWrite = 1, PCWrite = 1 (PCSrc = 0), go to DECODE.
- DECODE:
  - Reg2Loc = 1 for STORE/CBZ/CBNZ, else 0 (held through EXEC/MEM).
  - Latch class.
  - ILL → pulse illegal, go to FETCH. Otherwise → EXEC.
- EXEC, by class:
  - RTYPE: ALUOp = 10, ALUSrc = 0, go to WB.
  - LOAD/STORE: ALUOp = 00, ALUSrc = 1, go to MEM.
  - CBZ/CBNZ: ALUOp = 01. PCWrite = PCSrc = 1 iff (CBZ & zero) | (CBNZ & ~zero). Go to FETCH.
  - B: PCWrite = PCSrc = 1, go to FETCH.
  - BL: as B, plus RegWrite = WRegLoc = 1 (X30 ← return address), go to FETCH.
- MEM:
  - dmem_req = 1, MemRead (LOAD) or MemWrite (STORE) held until dmem_ready.
  - On dmem_ready: LOAD → WB, STORE → FETCH.
- WB: RegWrite = 1, MemtoReg = (class == LOAD), go to FETCH.
- Latency with zero-wait memory:
  - RTYPE 4 cycles, LOAD 5, STORE 4, CB/B/BL 3, ILL 2.
- Watchdog:
  - The counter clears on entry to FETCH/MEM and increments each cycle ready is low.
  - When it reaches WAIT_MAX without ready: pulse bus_err, drop the request, no write, go to FETCH.
  - After a MEM timeout the PC has already advanced, so the instruction is skipped.
  - Ready arriving in the same cycle the count hits WAIT_MAX wins (no error).
- Stray imem_ready/dmem_ready outside FETCH/MEM is ignored.
- WRegLoc = 1 only in BL EXEC.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - state enum {FETCH, DECODE, EXEC, MEM, WB}
  - class enum {NOP, RTYPE, LOAD, STORE, CBZ, CBNZ, B, BL, ILL}
  - opcode constants
  - ALUOp encodings
- Sub-module legv8_opdecode: purely combinational, inst[31:21] → class. The FSM, watchdog and output decode stay in the top.

Test Plan:
- LDUR 0xF84402C9, imem_ready/dmem_ready tied high → strobes:
  - FETCH: IRWrite, PCWrite
  - DECODE: Reg2Loc = 0
  - EXEC: ALUSrc = 1, ALUOp = 00
  - MEM: MemRead
  - WB: RegWrite = 1, MemtoReg = 1
  - Back in FETCH at cycle 6.
- ADD 0x8B09026A then STUR 0xF80602CB:
  - ADD: RegWrite = 1 in WB, MemtoReg = 0, 4 cycles.
  - STUR: Reg2Loc = 1, MemWrite in MEM, RegWrite never asserted, 4 cycles.
- CBZ 0xB4FFFF6B with zero = 1 → PCWrite = PCSrc = 1 in EXEC. With zero = 0 → PCWrite = 0. CBNZ 0xB5000109 gives the inverse.
- BL 0x94000010 → RegWrite = WRegLoc = PCWrite = PCSrc = 1 in EXEC. B 0x14000040 → same but RegWrite = WRegLoc = 0.
- Timeout and illegal:
  - dmem_ready held low on LDUR → bus_err pulses after 16 MEM cycles, no RegWrite, returns to FETCH.
  - inst = 0x00000000 → illegal pulse in DECODE.
- rst asserted mid-MEM of LDUR → all outputs 0 immediately. After release the FSM starts in FETCH with imem_req = 1, and no WB occurs.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle control unit.
//   state_e : FSM states
//   cls_e   : instruction class latched in DECODE
//   Op*     : opcode field values compared against inst[31:21] (or its prefixes)
//   AluOp*  : ALUOp encodings driven to the ALU control
package legv8_ctrl_pkg;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb
   } state_e;

   typedef enum logic [3:0] {
      ClsNop,
      ClsRtype,
      ClsLoad,
      ClsStore,
      ClsCbz,
      ClsCbnz,
      ClsB,
      ClsBl,
      ClsIll
   } cls_e;

   // Full 11-bit opcodes, inst[31:21]
   localparam logic [10:0] OpAdd  = 11'h458;
   localparam logic [10:0] OpSub  = 11'h658;
   localparam logic [10:0] OpAnd  = 11'h450;
   localparam logic [10:0] OpOrr  = 11'h550;
   localparam logic [10:0] OpLdur = 11'h7C2;
   localparam logic [10:0] OpStur = 11'h7C0;
   // CB-format, inst[31:24]
   localparam logic [7:0]  OpCbz  = 8'hB4;
   localparam logic [7:0]  OpCbnz = 8'hB5;
   // B-format, inst[31:26]
   localparam logic [5:0]  OpB    = 6'h05;
   localparam logic [5:0]  OpBl   = 6'h25;

   localparam logic [1:0]  AluOpAdd   = 2'b00;
   localparam logic [1:0]  AluOpPassB = 2'b01;
   localparam logic [1:0]  AluOpRtype = 2'b10;

   // Classes whose second source register lives in the Rt field
   function automatic logic uses_rt(cls_e c);
      return (c == ClsStore) || (c == ClsCbz) || (c == ClsCbnz);
   endfunction

endpackage

// File: rtl/legv8_opdecode.sv
// Combinational opcode classifier.
//   opcode_i : inst[31:21]
//   cls_o    : instruction class (ClsIll for anything not recognised)
module legv8_opdecode
   import legv8_ctrl_pkg::*;
(
   input  logic [10:0] opcode_i,
   output cls_e        cls_o
);

   always_comb begin
      cls_o = ClsIll;
      if ((opcode_i == OpAdd) || (opcode_i == OpSub) ||
          (opcode_i == OpAnd) || (opcode_i == OpOrr)) begin
         cls_o = ClsRtype;
      end else if (opcode_i == OpLdur) begin
         cls_o = ClsLoad;
      end else if (opcode_i == OpStur) begin
         cls_o = ClsStore;
      end else if (opcode_i[10:3] == OpCbz) begin
         cls_o = ClsCbz;
      end else if (opcode_i[10:3] == OpCbnz) begin
         cls_o = ClsCbnz;
      end else if (opcode_i[10:5] == OpB) begin
         cls_o = ClsB;
      end else if (opcode_i[10:5] == OpBl) begin
         cls_o = ClsBl;
      end
   end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle control FSM for the LEGv8 core: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Inputs : clk, rst (async, active high), inst, zero, imem_ready, dmem_ready
// Outputs: memory requests (imem_req, dmem_req, MemRead, MemWrite), PC/IR strobes
//          (IRWrite, PCWrite, PCSrc), ID-stage selects (RegWrite, Reg2Loc, WRegLoc),
//          EX selects (ALUSrc, ALUOp), write-back select (MemtoReg) and the
//          one-cycle error pulses illegal and bus_err.
// FETCH and MEM wait on their ready input under a watchdog; a timeout pulses bus_err
// and restarts at FETCH.
module legv8_multicycle_ctrl
   import legv8_ctrl_pkg::*;
#(
   parameter int unsigned INST_SIZE = 32,
   parameter int unsigned WAIT_MAX  = 16,
   parameter int unsigned WAIT_W    = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [INST_SIZE-1:0] inst,
   input  logic                 zero,
   input  logic                 imem_ready,
   input  logic                 dmem_ready,
   output logic                 imem_req,
   output logic                 dmem_req,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 PCSrc,
   output logic                 RegWrite,
   output logic                 Reg2Loc,
   output logic                 WRegLoc,
   output logic                 ALUSrc,
   output logic [1:0]           ALUOp,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 MemtoReg,
   output logic                 illegal,
   output logic                 bus_err
);

   state_e              state_q, state_d;
   cls_e                cls_q, cls_d;
   cls_e                dec_cls;
   logic [WAIT_W-1:0]   cnt_q, cnt_d;
   logic                timeout;
   logic                unused_inst;

   // Only the opcode field matters here; the rest feeds the datapath.
   assign unused_inst = ^inst;

   legv8_opdecode u_opdecode (
      .opcode_i (inst[31:21]),
      .cls_o    (dec_cls)
   );

   assign timeout = (cnt_q == WAIT_W'(WAIT_MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
         cls_q   <= ClsNop;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cls_d    = cls_q;
      cnt_d    = '0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      RegWrite = 1'b0;
      Reg2Loc  = 1'b0;
      WRegLoc  = 1'b0;
      ALUSrc   = 1'b0;
      ALUOp    = AluOpAdd;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      illegal  = 1'b0;
      bus_err  = 1'b0;

      unique case (state_q)
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = StDecode;
            end else if (timeout) begin
               bus_err = 1'b1;   // counter restarts from 0, fetch retried
            end else begin
               cnt_d = cnt_q + WAIT_W'(1);
            end
         end

         StDecode: begin
            // cls_q is not yet valid here, so use the live decode
            cls_d   = dec_cls;
            Reg2Loc = uses_rt(dec_cls);
            if (dec_cls == ClsIll) begin
               illegal = 1'b1;
               state_d = StFetch;
            end else begin
               state_d = StExec;
            end
         end

         StExec: begin
            Reg2Loc = uses_rt(cls_q);
            case (cls_q)
               ClsRtype: begin
                  ALUOp   = AluOpRtype;
                  state_d = StWb;
               end
               ClsLoad, ClsStore: begin
                  ALUSrc  = 1'b1;
                  state_d = StMem;
               end
               ClsCbz, ClsCbnz: begin
                  ALUOp   = AluOpPassB;
                  PCWrite = ((cls_q == ClsCbz) && zero) || ((cls_q == ClsCbnz) && !zero);
                  PCSrc   = PCWrite;
                  state_d = StFetch;
               end
               ClsB: begin
                  PCWrite = 1'b1;
                  PCSrc   = 1'b1;
                  state_d = StFetch;
               end
               ClsBl: begin
                  PCWrite  = 1'b1;
                  PCSrc    = 1'b1;
                  RegWrite = 1'b1;
                  WRegLoc  = 1'b1;
                  state_d  = StFetch;
               end
               default: state_d = StFetch;
            endcase
         end

         StMem: begin
            Reg2Loc  = uses_rt(cls_q);
            dmem_req = 1'b1;
            MemRead  = (cls_q == ClsLoad);
            MemWrite = (cls_q == ClsStore);
            if (dmem_ready) begin
               state_d = (cls_q == ClsLoad) ? StWb : StFetch;
            end else if (timeout) begin
               // PC already advanced in FETCH: the instruction is dropped
               bus_err = 1'b1;
               state_d = StFetch;
            end else begin
               cnt_d = cnt_q + WAIT_W'(1);
            end
         end

         StWb: begin
            RegWrite = 1'b1;
            MemtoReg = (cls_q == ClsLoad);
            state_d  = StFetch;
         end

         default: state_d = StFetch;
      endcase

      // Force every strobe low while reset is asserted, independent of the clock
      if (rst) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         PCSrc    = 1'b0;
         RegWrite = 1'b0;
         Reg2Loc  = 1'b0;
         WRegLoc  = 1'b0;
         ALUSrc   = 1'b0;
         ALUOp    = AluOpAdd;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         MemtoReg = 1'b0;
         illegal  = 1'b0;
         bus_err  = 1'b0;
      end
   end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed self-checking bench for legv8_multicycle_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 ns later as a packed vector.
module tb_legv8_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic        zero, imem_ready, dmem_ready;
   logic        imem_req, dmem_req, IRWrite, PCWrite, PCSrc, RegWrite, Reg2Loc, WRegLoc;
   logic        ALUSrc, MemRead, MemWrite, MemtoReg, illegal, bus_err;
   logic [1:0]  ALUOp;

   logic [15:0] obs;
   int          tests_run = 0;
   int          fails     = 0;

   // Output vector bit masks
   localparam logic [15:0] IMREQ = 16'h8000;
   localparam logic [15:0] DMREQ = 16'h4000;
   localparam logic [15:0] IRW   = 16'h2000;
   localparam logic [15:0] PCW   = 16'h1000;
   localparam logic [15:0] PCS   = 16'h0800;
   localparam logic [15:0] RW    = 16'h0400;
   localparam logic [15:0] R2L   = 16'h0200;
   localparam logic [15:0] WRL   = 16'h0100;
   localparam logic [15:0] ALUS  = 16'h0080;
   localparam logic [15:0] AOPR  = 16'h0040;  // ALUOp = 10
   localparam logic [15:0] AOPB  = 16'h0020;  // ALUOp = 01
   localparam logic [15:0] MR    = 16'h0010;
   localparam logic [15:0] MW    = 16'h0008;
   localparam logic [15:0] M2R   = 16'h0004;
   localparam logic [15:0] ILLP  = 16'h0002;
   localparam logic [15:0] BERR  = 16'h0001;
   localparam logic [15:0] FETCHED = IMREQ | IRW | PCW;

   localparam logic [31:0] I_LDUR = 32'hF84402C9;
   localparam logic [31:0] I_ADD  = 32'h8B09026A;
   localparam logic [31:0] I_STUR = 32'hF80602CB;
   localparam logic [31:0] I_CBZ  = 32'hB4FFFF6B;
   localparam logic [31:0] I_CBNZ = 32'hB5000109;
   localparam logic [31:0] I_BL   = 32'h94000010;
   localparam logic [31:0] I_B    = 32'h14000040;

   legv8_multicycle_ctrl #(
      .INST_SIZE (32),
      .WAIT_MAX  (16),
      .WAIT_W    (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .inst       (inst),
      .zero       (zero),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .dmem_req   (dmem_req),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .PCSrc      (PCSrc),
      .RegWrite   (RegWrite),
      .Reg2Loc    (Reg2Loc),
      .WRegLoc    (WRegLoc),
      .ALUSrc     (ALUSrc),
      .ALUOp      (ALUOp),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .MemtoReg   (MemtoReg),
      .illegal    (illegal),
      .bus_err    (bus_err)
   );

   always #5 clk = ~clk;

   task automatic sample();
      #1;
      obs = {imem_req, dmem_req, IRWrite, PCWrite, PCSrc, RegWrite, Reg2Loc, WRegLoc,
             ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, illegal, bus_err};
   endtask

   task automatic advance();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; inst = '0; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
      repeat (2) @(negedge clk);
      sample();
      tests_run++;
      if (obs !== 16'h0) begin
         fails++; $display("FAIL reset_hold: got %h want %h", obs, 16'h0);
      end
      rst = 1'b0; imem_ready = 1'b0;
      sample();
      tests_run++;
      if (obs !== IMREQ) begin
         fails++; $display("FAIL reset_release: got %h want %h", obs, IMREQ);
      end
      advance();
   endtask

   task automatic test_ldur();
      logic [15:0] exp [6];
      exp = '{FETCHED, 16'h0, ALUS, DMREQ | MR, RW | M2R, IMREQ};
      inst = I_LDUR; zero = 1'b0; dmem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         imem_ready = (i != 5);
         sample();
         tests_run++;
         if (obs !== exp[i]) begin
            fails++; $display("FAIL ldur cyc%0d: got %h want %h", i, obs, exp[i]);
         end
         advance();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp [9];
      exp = '{FETCHED, 16'h0, AOPR, RW,
              FETCHED, R2L, R2L | ALUS, R2L | DMREQ | MW, IMREQ};
      zero = 1'b0; dmem_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         inst       = (i < 4) ? I_ADD : I_STUR;
         imem_ready = (i != 8);
         sample();
         tests_run++;
         if (obs !== exp[i]) begin
            fails++; $display("FAIL add_stur cyc%0d: got %h want %h", i, obs, exp[i]);
         end
         advance();
      end
   endtask

   task automatic test_cond_branch(input logic [31:0] ins, input logic z, input logic taken);
      logic [15:0] exp [4];
      exp = '{FETCHED, R2L, R2L | AOPB | (taken ? (PCW | PCS) : 16'h0), IMREQ};
      inst = ins; zero = z; dmem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         imem_ready = (i == 0);
         sample();
         tests_run++;
         if (obs !== exp[i]) begin
            fails++;
            $display("FAIL cb %h z=%0b cyc%0d: got %h want %h", ins, z, i, obs, exp[i]);
         end
         advance();
      end
   endtask

   task automatic test_branch(input logic [31:0] ins, input logic link);
      logic [15:0] exp [4];
      exp = '{FETCHED, 16'h0, PCW | PCS | (link ? (RW | WRL) : 16'h0), IMREQ};
      inst = ins; zero = 1'b1; dmem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         imem_ready = (i == 0);
         sample();
         tests_run++;
         if (obs !== exp[i]) begin
            fails++; $display("FAIL b link=%0b cyc%0d: got %h want %h", link, i, obs, exp[i]);
         end
         advance();
      end
   endtask

   // Illegal opcode, then imem_ready held low to exercise the fetch watchdog
   task automatic test_illegal();
      logic [15:0] want;
      inst = 32'h0; zero = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b1;
      sample();
      tests_run++;
      if (obs !== FETCHED) begin
         fails++; $display("FAIL ill_fetch: got %h want %h", obs, FETCHED);
      end
      advance();
      imem_ready = 1'b0;
      sample();
      tests_run++;
      if (obs !== ILLP) begin
         fails++; $display("FAIL ill_decode: got %h want %h", obs, ILLP);
      end
      advance();
      for (int i = 0; i < 18; i++) begin
         want = (i == 16) ? (IMREQ | BERR) : IMREQ;
         sample();
         tests_run++;
         if (obs !== want) begin
            fails++; $display("FAIL fetch_wdog cyc%0d: got %h want %h", i, obs, want);
         end
         advance();
      end
   endtask

   // mode 0: dmem never ready -> bus_err; mode 1: ready on the last allowed cycle wins
   task automatic test_mem_timeout(input int mode);
      logic [15:0] want;
      inst = I_LDUR; zero = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b1;
      advance();   // FETCH (already covered elsewhere)
      imem_ready = 1'b0;
      advance();   // DECODE
      advance();   // EXEC
      for (int i = 0; i < 17; i++) begin
         dmem_ready = (mode == 1) && (i == 16);
         want = DMREQ | MR | (((mode == 0) && (i == 16)) ? BERR : 16'h0);
         sample();
         tests_run++;
         if (obs !== want) begin
            fails++; $display("FAIL mem_wdog m%0d cyc%0d: got %h want %h", mode, i, obs, want);
         end
         advance();
      end
      dmem_ready = 1'b0;
      want = (mode == 0) ? IMREQ : (RW | M2R);
      sample();
      tests_run++;
      if (obs !== want) begin
         fails++; $display("FAIL mem_wdog_after m%0d: got %h want %h", mode, obs, want);
      end
      advance();
      if (mode == 1) begin
         sample();
         tests_run++;
         if (obs !== IMREQ) begin
            fails++; $display("FAIL mem_wdog_refetch: got %h want %h", obs, IMREQ);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_mem();
      inst = I_LDUR; zero = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b1;
      advance();   // FETCH
      imem_ready = 1'b0;
      advance();   // DECODE
      advance();   // EXEC
      sample();
      tests_run++;
      if (obs !== (DMREQ | MR)) begin
         fails++; $display("FAIL rst_mem_pre: got %h want %h", obs, DMREQ | MR);
      end
      #1 rst = 1'b1;
      sample();
      tests_run++;
      if (obs !== 16'h0) begin
         fails++; $display("FAIL rst_async: got %h want %h", obs, 16'h0);
      end
      advance();
      dmem_ready = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         tests_run++;
         if (obs !== IMREQ) begin
            fails++; $display("FAIL rst_after cyc%0d: got %h want %h", i, obs, IMREQ);
         end
         advance();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running want done");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ldur();
      test_back_to_back();
      test_cond_branch(I_CBZ,  1'b1, 1'b1);
      test_cond_branch(I_CBZ,  1'b0, 1'b0);
      test_cond_branch(I_CBNZ, 1'b0, 1'b1);
      test_cond_branch(I_CBNZ, 1'b1, 1'b0);
      test_branch(I_BL, 1'b1);
      test_branch(I_B,  1'b0);
      test_illegal();
      test_mem_timeout(0);
      test_mem_timeout(1);
      test_reset_mid_mem();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
